// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
//   Shared definitions for the router byte register stage.
//   - PAR_XOR / PAR_XNOR : parity mode selectors (even / odd parity seed).
//   - hdr_addr()         : destination field of a header byte.
//   - hdr_len()          : payload length field of a header byte.
//   The header functions work on a zero-extended 32-bit view of the header
//   so they can serve any DATA_W/ADDR_W split up to 32 bits.
// ---------------------------------------------------------------------------
package router_pkg;

   localparam int unsigned PAR_XOR  = 0;
   localparam int unsigned PAR_XNOR = 1;

   function automatic int unsigned hdr_addr(input logic [31:0] hdr, input int unsigned addr_w);
      return hdr & ((32'd1 << addr_w) - 32'd1);
   endfunction

   function automatic int unsigned hdr_len(input logic [31:0] hdr, input int unsigned addr_w);
      return hdr >> addr_w;
   endfunction

endpackage

// File: rtl/router_pkt_reg_if.sv
// ---------------------------------------------------------------------------
// router_pkt_reg_if
//   Bundle between the router input FSM / source and the byte register stage.
//   master : drives pkt_valid, fifo_full, FSM state strobes, rst_int_reg,
//            data_in; observes the register-stage outputs.
//   slave  : the register stage (router_pkt_reg).
// ---------------------------------------------------------------------------
interface router_pkt_reg_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 2
);
   logic              pkt_valid;
   logic              fifo_full;
   logic              detect_add;
   logic              lfd_state;
   logic              ld_state;
   logic              laf_state;
   logic              full_state;
   logic              rst_int_reg;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] dout;
   logic [ADDR_W-1:0] dest_addr;
   logic              hdr_valid;
   logic              low_pkt_valid;
   logic              parity_done;
   logic              err;
   logic              err_len;

   modport master (
      output pkt_valid, fifo_full, detect_add, lfd_state, ld_state, laf_state,
             full_state, rst_int_reg, data_in,
      input  dout, dest_addr, hdr_valid, low_pkt_valid, parity_done, err, err_len
   );

   modport slave (
      input  pkt_valid, fifo_full, detect_add, lfd_state, ld_state, laf_state,
             full_state, rst_int_reg, data_in,
      output dout, dest_addr, hdr_valid, low_pkt_valid, parity_done, err, err_len
   );
endinterface

// File: rtl/router_parity_acc.sv
// ---------------------------------------------------------------------------
// router_parity_acc
//   Running parity over header + payload, packet parity capture, and the
//   end-of-packet parity / length checks.
//   Ports:
//     clock, reset        clock and synchronous active-high reset
//     detect_add ...      FSM state strobes (mutually exclusive)
//     fifo_full           selected output FIFO full
//     pkt_valid           source packet valid
//     low_pkt_valid       pkt_valid fell during load (from top)
//     parity_done         parity byte captured (from top)
//     hdr, data_in, hold  latched header, live byte, byte held while full
//     err, err_len        parity mismatch / payload length mismatch
// ---------------------------------------------------------------------------
module router_parity_acc
   import router_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ADDR_W      = 2,
   parameter int unsigned PARITY_MODE = PAR_XOR,
   parameter int unsigned LEN_CHECK   = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              detect_add,
   input  logic              lfd_state,
   input  logic              ld_state,
   input  logic              laf_state,
   input  logic              full_state,
   input  logic              fifo_full,
   input  logic              pkt_valid,
   input  logic              low_pkt_valid,
   input  logic              parity_done,
   input  logic [DATA_W-1:0] hdr,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] hold,
   output logic              err,
   output logic              err_len
);
   localparam int unsigned       LEN_W = DATA_W - ADDR_W;
   localparam logic [DATA_W-1:0] SEED  = (PARITY_MODE == PAR_XNOR) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};

   logic [DATA_W-1:0] int_par;
   logic [DATA_W-1:0] pkt_par;
   logic [LEN_W-1:0]  pay_cnt;
   logic [LEN_W-1:0]  len_field;
   logic              pd_prev;

   assign len_field = LEN_W'(hdr_len(32'(hdr), ADDR_W));

   always_ff @(posedge clock) begin
      if (reset) begin
         int_par <= SEED;
         pkt_par <= '0;
         pay_cnt <= '0;
         pd_prev <= 1'b0;
         err     <= 1'b0;
         err_len <= 1'b0;
      end else begin
         pd_prev <= parity_done;

         if (detect_add) begin
            int_par <= SEED;
            pay_cnt <= '0;
         end else if (lfd_state) begin
            int_par <= int_par ^ hdr;
         end else if (ld_state && pkt_valid && !full_state) begin
            int_par <= int_par ^ data_in;
            // Saturate rather than wrap so an overlong packet cannot alias
            // back onto a short length field.
            if (pay_cnt != {LEN_W{1'b1}})
               pay_cnt <= pay_cnt + LEN_W'(1);
         end

         // A parity byte that arrived while the FIFO was full sits in hold.
         if (ld_state && !pkt_valid && !fifo_full)
            pkt_par <= data_in;
         else if (laf_state && low_pkt_valid && !parity_done)
            pkt_par <= hold;

         // Checks fire once, the cycle after parity_done rises, and stay
         // until the next header.
         if (detect_add) begin
            err     <= 1'b0;
            err_len <= 1'b0;
         end else if (parity_done && !pd_prev) begin
            err     <= (int_par != pkt_par);
            err_len <= (LEN_CHECK != 0) && (pay_cnt != len_field);
         end
      end
   end

endmodule

// File: rtl/router_pkt_reg.sv
// ---------------------------------------------------------------------------
// router_pkt_reg
//   Router byte register stage between the input FSM and the output FIFOs.
//   Latches the header, steers header / payload / held byte onto dout,
//   tracks low_pkt_valid and parity_done, and hosts the parity/length
//   checker.
//   Ports:
//     clock  single clock, posedge
//     reset  synchronous, active-high
//     bus    router_pkt_reg_if.slave: FSM strobes, pkt_valid, fifo_full,
//            rst_int_reg, data_in in; dout, dest_addr, hdr_valid,
//            low_pkt_valid, parity_done, err, err_len out
// ---------------------------------------------------------------------------
module router_pkt_reg
   import router_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ADDR_W      = 2,
   parameter int unsigned NUM_CH      = 3,
   parameter int unsigned PARITY_MODE = PAR_XOR,
   parameter int unsigned LEN_CHECK   = 1
) (
   input  logic           clock,
   input  logic           reset,
   router_pkt_reg_if.slave bus
);
   logic [DATA_W-1:0] hdr;
   logic [DATA_W-1:0] hold;
   logic [DATA_W-1:0] dout_r;
   logic [DATA_W-1:0] data_in;
   logic              hdr_valid_r;
   logic              lpv_r;
   logic              pd_r;
   logic              addr_ok;
   logic              err_w;
   logic              err_len_w;

   assign data_in = bus.data_in;
   assign addr_ok = hdr_addr(32'(data_in), ADDR_W) < NUM_CH;

   always_ff @(posedge clock) begin
      if (reset) begin
         hdr         <= '0;
         hold        <= '0;
         dout_r      <= '0;
         hdr_valid_r <= 1'b0;
         lpv_r       <= 1'b0;
         pd_r        <= 1'b0;
      end else begin
         // A bad destination leaves the previous header intact.
         if (bus.detect_add && bus.pkt_valid && addr_ok) begin
            hdr         <= data_in;
            hdr_valid_r <= 1'b1;
         end else if (bus.detect_add && !addr_ok) begin
            hdr_valid_r <= 1'b0;
         end

         if (bus.lfd_state)
            dout_r <= hdr;
         else if (bus.ld_state && !bus.fifo_full)
            dout_r <= data_in;
         else if (bus.ld_state && bus.fifo_full)
            hold <= data_in;
         else if (bus.laf_state)
            dout_r <= hold;

         // Clear takes priority over set.
         if (bus.rst_int_reg)
            lpv_r <= 1'b0;
         else if (bus.ld_state && !bus.pkt_valid)
            lpv_r <= 1'b1;

         if (bus.detect_add)
            pd_r <= 1'b0;
         else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
                  (bus.laf_state && lpv_r && !pd_r))
            pd_r <= 1'b1;
      end
   end

   router_parity_acc #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .PARITY_MODE (PARITY_MODE),
      .LEN_CHECK   (LEN_CHECK)
   ) u_parity (
      .clock         (clock),
      .reset         (reset),
      .detect_add    (bus.detect_add),
      .lfd_state     (bus.lfd_state),
      .ld_state      (bus.ld_state),
      .laf_state     (bus.laf_state),
      .full_state    (bus.full_state),
      .fifo_full     (bus.fifo_full),
      .pkt_valid     (bus.pkt_valid),
      .low_pkt_valid (lpv_r),
      .parity_done   (pd_r),
      .hdr           (hdr),
      .data_in       (data_in),
      .hold          (hold),
      .err           (err_w),
      .err_len       (err_len_w)
   );

   assign bus.dout          = dout_r;
   assign bus.dest_addr     = ADDR_W'(hdr_addr(32'(hdr), ADDR_W));
   assign bus.hdr_valid     = hdr_valid_r;
   assign bus.low_pkt_valid = lpv_r;
   assign bus.parity_done   = pd_r;
   assign bus.err           = err_w;
   assign bus.err_len       = err_len_w;

endmodule
